// File: rtl/qspi_resp_pkg.sv
// rtl/qspi_resp_pkg.sv - shared states, transfer kinds and opcodes for the QPI PSRAM responder
package qspi_resp_pkg;

   typedef enum logic [2:0] {
      SPI_CMD,
      CMD,
      ADDR,
      MODE,
      DUMMY,
      RD,
      WR,
      IGNORE
   } state_e;

   typedef enum logic [1:0] {
      XFER_RD,
      XFER_WR,
      XFER_QIO
   } xfer_e;

   localparam logic [7:0] OP_QPI_EN    = 8'h35;
   localparam logic [7:0] OP_QRD       = 8'h0B;
   localparam logic [7:0] OP_QWR       = 8'h38;
   localparam logic [7:0] OP_QIORD     = 8'hEB;
   localparam logic [3:0] CRM_MODE_NIB = 4'hA;

   localparam int CNT_W = 8;

endpackage

// File: rtl/qspi_resp_mem.sv
// rtl/qspi_resp_mem.sv - byte-wide single-port array, synchronous write, asynchronous read
module qspi_resp_mem #(
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [ADDR_W-1:0] adr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);

   logic [7:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem_q[adr] <= wdata;
      end
   end

   assign rdata = mem_q[adr];

endmodule

// File: rtl/qspi_psram_responder.sv
// rtl/qspi_psram_responder.sv - QPI PSRAM responder (0x35/0x0B/0x38); QSPI_RESP_CRM_EN adds 0xEB continuous read
module qspi_psram_responder
   import qspi_resp_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DUMMY_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cs_in,
   input  logic [3:0] sd_i,
   output logic [3:0] sd_o,
   output logic [3:0] sd_oen_o,
   output logic       qpi_mode_o
);

   state_e            state_q, state_d;
   xfer_e             xfer_q, xfer_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] sh_q, sh_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic              half_q, half_d;
   logic [3:0]        wr_hi_q, wr_hi_d;
   logic [3:0]        sd_d, oen_d;
   logic              qpi_d;
   logic              mem_we;
   logic [7:0]        mem_rdata;
`ifdef QSPI_RESP_CRM_EN
   logic              crm_q, crm_d;
`endif

   qspi_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk_i (clk_i),
      .we    (mem_we),
      .adr   (adr_q),
      .wdata ({wr_hi_q, sd_i}),
      .rdata (mem_rdata)
   );

   // The shifter only keeps ADDR_W bits, so upper address bits fall off (aliasing).
   always_comb begin
      state_d = state_q;
      xfer_d  = xfer_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      adr_d   = adr_q;
      half_d  = half_q;
      wr_hi_d = wr_hi_q;
      sd_d    = sd_o;
      oen_d   = 4'h0;
      qpi_d   = qpi_mode_o;
      mem_we  = 1'b0;
`ifdef QSPI_RESP_CRM_EN
      crm_d   = crm_q;
`endif
      if (cs_in) begin
         cnt_d  = '0;
         half_d = 1'b0;
         state_d = qpi_mode_o ? CMD : SPI_CMD;
`ifdef QSPI_RESP_CRM_EN
         if (crm_q) begin
            state_d = ADDR;
            xfer_d  = XFER_QIO;
         end
`endif
      end else begin
         cnt_d = cnt_q + 1'b1;
         case (state_q)
            SPI_CMD: begin
               sh_d = ADDR_W'({sh_q, sd_i[0]});
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d   = '0;
                  state_d = IGNORE;
                  if (sh_d[7:0] == OP_QPI_EN) begin
                     qpi_d = 1'b1;
                  end
`ifdef QSPI_RESP_CRM_EN
                  else if (sh_d[7:0] == OP_QIORD) begin
                     state_d = ADDR;
                     xfer_d  = XFER_QIO;
                  end
`endif
               end
            end
            CMD: begin
               sh_d = ADDR_W'({sh_q, sd_i});
               if (cnt_q == CNT_W'(1)) begin
                  cnt_d = '0;
                  case (sh_d[7:0])
                     OP_QRD: begin
                        state_d = ADDR;
                        xfer_d  = XFER_RD;
                     end
                     OP_QWR: begin
                        state_d = ADDR;
                        xfer_d  = XFER_WR;
                     end
                     default: state_d = IGNORE;
                  endcase
               end
            end
            ADDR: begin
               sh_d = ADDR_W'({sh_q, sd_i});
               if (cnt_q == CNT_W'(5)) begin
                  cnt_d = '0;
                  adr_d = sh_d;
                  if (xfer_q == XFER_WR)       state_d = WR;
                  else if (xfer_q == XFER_QIO) state_d = MODE;
                  else                         state_d = DUMMY;
               end
            end
            MODE: begin
               sh_d = ADDR_W'({sh_q, sd_i});
               if (cnt_q == CNT_W'(1)) begin
                  cnt_d   = '0;
                  state_d = DUMMY;
`ifdef QSPI_RESP_CRM_EN
                  crm_d   = (sh_q[3:0] == CRM_MODE_NIB);
`endif
               end
            end
            DUMMY: begin
               // Preload the high nibble so it is on the bus the cycle after the last dummy edge.
               if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                  cnt_d   = '0;
                  oen_d   = 4'hF;
                  sd_d    = mem_rdata[7:4];
                  half_d  = 1'b1;
                  state_d = RD;
               end
            end
            RD: begin
               oen_d = 4'hF;
               if (half_q) begin
                  sd_d   = mem_rdata[3:0];
                  adr_d  = adr_q + 1'b1;
                  half_d = 1'b0;
               end else begin
                  sd_d   = mem_rdata[7:4];
                  half_d = 1'b1;
               end
            end
            WR: begin
               if (half_q) begin
                  mem_we = 1'b1;
                  adr_d  = adr_q + 1'b1;
                  half_d = 1'b0;
               end else begin
                  wr_hi_d = sd_i;
                  half_d  = 1'b1;
               end
            end
            IGNORE: begin
            end
            default: state_d = SPI_CMD;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= SPI_CMD;
         xfer_q     <= XFER_RD;
         cnt_q      <= '0;
         sh_q       <= '0;
         adr_q      <= '0;
         half_q     <= 1'b0;
         wr_hi_q    <= 4'h0;
         sd_o       <= 4'h0;
         sd_oen_o   <= 4'h0;
         qpi_mode_o <= 1'b0;
`ifdef QSPI_RESP_CRM_EN
         crm_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         xfer_q     <= xfer_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         adr_q      <= adr_d;
         half_q     <= half_d;
         wr_hi_q    <= wr_hi_d;
         sd_o       <= sd_d;
         sd_oen_o   <= oen_d;
         qpi_mode_o <= qpi_d;
`ifdef QSPI_RESP_CRM_EN
         crm_q      <= crm_d;
`endif
      end
   end

endmodule

// File: tb/tb_qspi_psram_responder.sv
// tb/tb_qspi_psram_responder.sv - randomized bench for qspi_psram_responder against a byte-array memory model
module tb_qspi_psram_responder;

   localparam int ADDR_W = 10;
   localparam int DUMMY  = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs  = 1'b1;
   logic [3:0] sd  = 4'h0;
   logic [3:0] sd_o;
   logic [3:0] sd_oen;
   logic       qpi_mode;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] model [DEPTH];
   logic [7:0] wbuf [$];

   qspi_psram_responder #(.ADDR_W(ADDR_W), .DUMMY_CYCLES(DUMMY)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .cs_in      (cs),
      .sd_i       (sd),
      .sd_o       (sd_o),
      .sd_oen_o   (sd_oen),
      .qpi_mode_o (qpi_mode)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one clock: inputs change at the falling edge, outputs observed 1 ns after the rising edge.
   task automatic tick(input logic c, input logic [3:0] nib);
      @(negedge clk);
      cs = c;
      sd = nib;
      @(posedge clk);
      #1;
   endtask

   task automatic cs_idle();
      tick(1'b1, 4'($urandom));
      check_eq("oen_idle", sd_oen, 4'h0);
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, {3'b000, b[7-i]});
         check_eq("oen_spi", sd_oen, 4'h0);
      end
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, a[23-4*i -: 4]);
         check_eq("oen_addr", sd_oen, 4'h0);
      end
   endtask

   task automatic dummy_and_read(input logic [23:0] a, input int n);
      logic [7:0] exp;
      logic [3:0] enib;
      int         idx;
      for (int d = 0; d < DUMMY; d++) begin
         tick(1'b0, 4'($urandom));
         if (d < DUMMY - 1) check_eq("oen_dummy", sd_oen, 4'h0);
      end
      for (int k = 0; k < 2 * n; k++) begin
         if (k > 0) tick(1'b0, 4'($urandom));
         idx  = (int'(a) + k / 2) % DEPTH;
         exp  = model[idx];
         enib = (k % 2 == 1) ? exp[3:0] : exp[7:4];
         check_eq($sformatf("rd_nib@%0h.%0d", idx, k % 2), sd_o, enib);
         check_eq("oen_rd", sd_oen, 4'hF);
      end
   endtask

   task automatic qpi_read(input logic [23:0] a, input int n);
      tick(1'b0, 4'h0);
      tick(1'b0, 4'hB);
      send_addr(a);
      dummy_and_read(a, n);
      cs_idle();
   endtask

   task automatic qpi_write(input logic [23:0] a);
      logic [7:0] b;
      tick(1'b0, 4'h3);
      tick(1'b0, 4'h8);
      send_addr(a);
      for (int i = 0; i < wbuf.size(); i++) begin
         b = wbuf[i];
         tick(1'b0, b[7:4]);
         check_eq("oen_wr", sd_oen, 4'h0);
         tick(1'b0, b[3:0]);
         model[(int'(a) + i) % DEPTH] = b;
      end
      cs_idle();
   endtask

   initial begin
      // Reset state
      tick(1'b1, 4'h0);
      tick(1'b1, 4'h0);
      check_eq("rst_sd_o", sd_o, 4'h0);
      check_eq("rst_oen", sd_oen, 4'h0);
      check_eq("rst_qpi", qpi_mode, 1'b0);
      rst = 1'b0;
      cs_idle();

      // Non-0x35 SPI byte leaves the responder silent and in SPI mode
      spi_byte(8'h99);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 4'($urandom));
         check_eq("oen_spi_ignore", sd_oen, 4'h0);
      end
      cs_idle();
      check_eq("qpi_after_99", qpi_mode, 1'b0);

      spi_byte(8'h35);
      cs_idle();
      check_eq("qpi_after_35", qpi_mode, 1'b1);

      // Fill the whole array with one wrapping burst so every byte is known
      wbuf.delete();
      for (int i = 0; i < DEPTH; i++) wbuf.push_back(8'($urandom));
      qpi_write(24'($urandom));

      wbuf = '{8'h43, 8'h21};
      qpi_write(24'h000010);
      qpi_read(24'h000010, 2);

      wbuf = '{8'hAA, 8'hBB};
      qpi_write(24'h0003FF);
      qpi_read(24'h0003FE, 4);

      // Write cut short after three nibbles: first byte lands, second does not
      wbuf = '{8'h00, 8'h00};
      qpi_write(24'h000020);
      tick(1'b0, 4'h3);
      tick(1'b0, 4'h8);
      send_addr(24'h000020);
      tick(1'b0, 4'hA);
      tick(1'b0, 4'hB);
      tick(1'b0, 4'hC);
      cs_idle();
      model[32'h20] = 8'hAB;
      qpi_read(24'h000020, 2);

      // Unknown QPI opcode
      tick(1'b0, 4'h9);
      tick(1'b0, 4'h9);
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 4'($urandom));
         check_eq("oen_qpi_ignore", sd_oen, 4'h0);
      end
      cs_idle();
      check_eq("qpi_kept", qpi_mode, 1'b1);

      // Randomized bursts, including aliased upper address bits
      for (int t = 0; t < 16; t++) begin
         wbuf.delete();
         for (int i = 0; i < int'($urandom_range(1, 5)); i++) wbuf.push_back(8'($urandom));
         qpi_write(24'($urandom));
         qpi_read(24'($urandom), int'($urandom_range(1, 6)));
      end

      // Reset in the middle of a read burst
      tick(1'b0, 4'h0);
      tick(1'b0, 4'hB);
      send_addr(24'h000100);
      dummy_and_read(24'h000100, 1);
      rst = 1'b1;
      tick(1'b0, 4'h0);
      check_eq("midrst_oen", sd_oen, 4'h0);
      check_eq("midrst_sd_o", sd_o, 4'h0);
      check_eq("midrst_qpi", qpi_mode, 1'b0);
      rst = 1'b0;
      cs_idle();

`ifdef QSPI_RESP_CRM_EN
      spi_byte(8'hEB);
      send_addr(24'h000010);
      tick(1'b0, 4'hA);
      tick(1'b0, 4'h5);
      check_eq("oen_mode", sd_oen, 4'h0);
      dummy_and_read(24'h000010, 1);
      cs_idle();
      send_addr(24'h000011);
      tick(1'b0, 4'hF);
      tick(1'b0, 4'hF);
      dummy_and_read(24'h000011, 1);
      cs_idle();
      spi_byte(8'h35);
      cs_idle();
      check_eq("qpi_after_crm", qpi_mode, 1'b1);
`else
      spi_byte(8'hEB);
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 4'($urandom));
         check_eq("oen_eb_ignore", sd_oen, 4'h0);
      end
      cs_idle();
      check_eq("qpi_after_eb", qpi_mode, 1'b0);
      spi_byte(8'h35);
      cs_idle();
      check_eq("qpi_reenter", qpi_mode, 1'b1);
`endif

      qpi_read(24'($urandom), 3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
